serial_add_seq: RTL

SERIAL_ADD_SEQ -- requirements
Module: serial_add_seq

---
 rtl/serial_add_pkg.sv | 13 +
 rtl/adder_four_bit.sv | 19 +
 rtl/serial_add_seq.sv | 114 +++++++++++
 3 files changed

// File: rtl/serial_add_pkg.sv
// Shared definitions for the nibble-serial adder: nibble width,
// FSM state encoding and the nibble type used by the datapath.
package serial_add_pkg;

  localparam int NIBBLE_W = 4;

  typedef logic [NIBBLE_W-1:0] nibble_t;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/adder_four_bit.sv
// Shared 4-bit ripple adder with carry-in and carry-out; the only adder
// in the serial add sequencer, reused once per nibble.
module adder_four_bit
  import serial_add_pkg::*;
(
  input  logic    i_cin,
  input  nibble_t i_a,
  input  nibble_t i_b,
  output nibble_t o_sum,
  output logic    o_cout
);

  logic [NIBBLE_W:0] w_full;

  assign w_full = {1'b0, i_a} + {1'b0, i_b} + {{NIBBLE_W{1'b0}}, i_cin};
  assign o_sum  = w_full[NIBBLE_W-1:0];
  assign o_cout = w_full[NIBBLE_W];

endmodule

// File: rtl/serial_add_seq.sv
// Nibble-serial adder: {cout,sum} = a + b + cin computed one nibble per
// cycle, LSB first, through a single shared adder_four_bit.
// Optional macro SERIAL_ADD_SUB_EN adds a 'sub' input: a - b computed as
// a + ~b + 1, with cout = 1 meaning no borrow.
module serial_add_seq
  import serial_add_pkg::*;
#(
  parameter int NIBBLES = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [NIBBLE_W*NIBBLES-1:0] a,
  input  logic [NIBBLE_W*NIBBLES-1:0] b,
  input  logic                      cin,
`ifdef SERIAL_ADD_SUB_EN
  input  logic                      sub,
`endif
  output logic                      busy,
  output logic                      done,
  output logic [NIBBLE_W*NIBBLES-1:0] sum,
  output logic                      cout
);

  localparam int W     = NIBBLE_W * NIBBLES;
  localparam int CNT_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  logic [1:0]       r_state;
  logic [W-1:0]     r_a;
  logic [W-1:0]     r_b;
  logic [W-1:0]     r_acc;
  logic [W-1:0]     r_sum;
  logic             r_cout;
  logic             r_carry;
  logic [CNT_W-1:0] r_cnt;

  nibble_t          w_aNib;
  nibble_t          w_bNib;
  nibble_t          w_nibSum;
  logic             w_nibCout;
  logic [W-1:0]     w_accNext;
  logic             w_lastNib;

  assign w_aNib    = r_a[int'(r_cnt)*NIBBLE_W +: NIBBLE_W];
  assign w_bNib    = r_b[int'(r_cnt)*NIBBLE_W +: NIBBLE_W];
  assign w_lastNib = (r_cnt == CNT_W'(NIBBLES - 1));

  adder_four_bit uNibAdder (
    .i_cin  (r_carry),
    .i_a    (w_aNib),
    .i_b    (w_bNib),
    .o_sum  (w_nibSum),
    .o_cout (w_nibCout)
  );

  // Accumulator with the current nibble result merged in, so the final
  // nibble can go straight to sum on the edge that leaves RUN.
  always_comb begin
    w_accNext = r_acc;
    w_accNext[int'(r_cnt)*NIBBLE_W +: NIBBLE_W] = w_nibSum;
  end

  // Sequencer: capture operands on start, walk the nibbles, publish result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_acc   <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            r_a     <= a;
`ifdef SERIAL_ADD_SUB_EN
            r_b     <= sub ? ~b : b;
            r_carry <= sub ? 1'b1 : cin;
`else
            r_b     <= b;
            r_carry <= cin;
`endif
            r_cnt   <= '0;
            r_state <= ST_RUN;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_RUN: begin
          r_acc   <= w_accNext;
          r_carry <= w_nibCout;
          if (w_lastNib) begin
            r_sum   <= w_accNext;
            r_cout  <= w_nibCout;
            r_cnt   <= '0;
            r_state <= ST_DONE;
          end else begin
            r_cnt   <= r_cnt + CNT_W'(1);
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign busy = (r_state == ST_RUN);
  assign done = (r_state == ST_DONE);
  assign sum  = r_sum;
  assign cout = r_cout;

endmodule
